// File: rtl/cdc_word_serializer.sv
// Wide-to-narrow serializer feeding the two-phase CDC source, LSB slice first with a last flag; 1 cycle accept-to-first-beat.
// Backpressure: a beat is held stable until out_ready_i; a new word may be taken in the same cycle as the last beat leaves.
// Optional CDC_SER_PARITY_EN adds out_parity_o (even parity of the current beat).
module cdc_word_serializer #(
    parameter int WideWidth   = 64,
    parameter int NarrowWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [WideWidth-1:0]   in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [NarrowWidth-1:0] out_data_o,
    output logic                   out_last_o,
`ifdef CDC_SER_PARITY_EN
    output logic                   out_parity_o,
`endif
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    localparam int SafeNarrow = (NarrowWidth == 0) ? 1 : NarrowWidth;
    localparam int NumBeats   = WideWidth / SafeNarrow;
    localparam int CntWidth   = (NumBeats > 1) ? $clog2(NumBeats) : 1;

    if ((NarrowWidth == 0) || (NumBeats == 0) || ((WideWidth % SafeNarrow) != 0)) begin : g_bad_cfg
        $fatal(1, "cdc_word_serializer: WideWidth must be a positive multiple of NarrowWidth");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                                state_q, state_d;
    logic [NumBeats-1:0][NarrowWidth-1:0]  word_q, word_d;
    logic [CntWidth-1:0]                   cnt_q, cnt_d;
    logic                                  beat_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by SEND so out_last_o stays low while idle and after reset.
    assign beat_last = (state_q == SEND) && (cnt_q == CntWidth'(NumBeats - 1));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    word_d  = in_data_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    if (beat_last) begin
                        cnt_d = '0;
                        if (in_valid_i) begin
                            word_d = in_data_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The last-beat term lets a new word enter with no bubble between words.
    assign in_ready_o  = (state_q == IDLE) || (beat_last && out_ready_i);
    assign out_valid_o = (state_q == SEND);
    assign out_last_o  = beat_last;
    assign out_data_o  = word_q[cnt_q];

`ifdef CDC_SER_PARITY_EN
    assign out_parity_o = ^out_data_o;
`endif

endmodule

// File: tb/tb_cdc_word_serializer.sv
// Scoreboard bench for cdc_word_serializer: 64/16 instance with queue-based checking, plus a 16/16 single-beat instance.
module tb_cdc_word_serializer;

    localparam int WW = 64;
    localparam int NW = 16;
    localparam int NB = WW / NW;

    typedef struct packed {
        logic [NW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_parity;

    logic [15:0]   in1_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [15:0]   out1_data;
    logic          out1_last;
    logic          out1_valid;
    logic          out1_ready;
    logic          out1_parity;

    int    total = 0;
    int    bad   = 0;
    int    ready_mode = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    cdc_word_serializer #(.WideWidth(WW), .NarrowWidth(NW)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
`ifdef CDC_SER_PARITY_EN
        .out_parity_o(out_parity),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    cdc_word_serializer #(.WideWidth(16), .NarrowWidth(16)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in1_data),
        .in_valid_i  (in1_valid),
        .in_ready_o  (in1_ready),
        .out_data_o  (out1_data),
        .out_last_o  (out1_last),
`ifdef CDC_SER_PARITY_EN
        .out_parity_o(out1_parity),
`endif
        .out_valid_o (out1_valid),
        .out_ready_i (out1_ready)
    );

`ifndef CDC_SER_PARITY_EN
    assign out_parity  = 1'b0;
    assign out1_parity = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes NB beats, slice i = bits [i*NW +: NW], last on the final one.
    task automatic send(input logic [WW-1:0] w);
        bit acc;
        acc      = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                for (int i = 0; i < NB; i++) begin
                    exp_q.push_back('{data: w[i*NW +: NW], last: (i == NB - 1)});
                end
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: word %0h never accepted", w);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: model says valid iff beats are pending, ready iff nothing pending or the final beat leaves now.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready),
                  64'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
            if (out_valid && exp_q.size() != 0) begin
                check("out_data", 64'(out_data), 64'(exp_q[0].data));
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
`ifdef CDC_SER_PARITY_EN
                check("out_parity", 64'(out_parity), 64'(^exp_q[0].data));
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int idx;
        idx       = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready = ((idx % 4) == 0) || ((idx % 4) == 3);
                    idx++;
                end
            endcase
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w1;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in1_valid  = 1'b0;
        in1_data   = '0;
        out1_ready = 1'b1;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_parity", 64'(out_parity), 64'd0);
        check("rst1_out_valid", 64'(out1_valid), 64'd0);
        check("rst1_out_data", 64'(out1_data), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        send(64'h0123_4567_89AB_CDEF);
        idle(6);
        send(64'h0000_0000_0003_0001);
        idle(6);

        send(64'hAAAA_BBBB_CCCC_DDDD);
        send(64'h1111_2222_3333_4444);
        idle(10);

        ready_mode = 2;
        send(64'hFEDC_BA98_7654_3210);
        idle(20);
        ready_mode = 1;
        repeat (30) begin
            send({$urandom, $urandom});
            if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(0, 5)));
        end
        idle(40);
        ready_mode = 0;
        idle(4);

        // Reset after beat 1 has been handed off.
        send(64'hDEAD_BEEF_CAFE_F00D);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_last", 64'(out_last), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        send(64'h5555_6666_7777_8888);
        idle(8);

        // Single-beat instance.
        in1_data  = 16'hA5A5;
        in1_valid = 1'b1;
        @(negedge clk);
        check("nb1_in_ready", 64'(in1_ready), 64'd1);
        @(posedge clk);
        #1 in1_valid = 1'b0;
        @(negedge clk);
        check("nb1_out_valid", 64'(out1_valid), 64'd1);
        check("nb1_out_data", 64'(out1_data), 64'hA5A5);
        check("nb1_out_last", 64'(out1_last), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("nb1_idle_valid", 64'(out1_valid), 64'd0);
        @(posedge clk);
        #1;
        repeat (8) begin
            w1         = 16'($urandom);
            in1_data   = w1;
            in1_valid  = 1'b1;
            out1_ready = 1'b0;
            @(negedge clk);
            check("nb1s_in_ready_idle", 64'(in1_ready), 64'd1);
            @(posedge clk);
            #1 in1_valid = 1'b0;
            @(negedge clk);
            check("nb1s_valid", 64'(out1_valid), 64'd1);
            check("nb1s_data", 64'(out1_data), 64'(w1));
            check("nb1s_in_ready_stall", 64'(in1_ready), 64'd0);
            @(posedge clk);
            #1 out1_ready = 1'b1;
            @(negedge clk);
            check("nb1s_data_held", 64'(out1_data), 64'(w1));
            check("nb1s_last", 64'(out1_last), 64'd1);
            check("nb1s_in_ready_last", 64'(in1_ready), 64'd1);
`ifdef CDC_SER_PARITY_EN
            check("nb1s_parity", 64'(out1_parity), 64'(^w1));
`endif
            @(posedge clk);
            #1;
        end
        idle(2);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
